// File: rtl/div_unit.sv
// Radix-2 restoring integer divider for the RV64M DIV/REM family, one quotient bit per cycle.
// Divide-by-zero and signed overflow take a fast path straight to DONE.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [3:0]  control,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result_out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic        is_w_q, is_w_d, is_rem_q, is_rem_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic        fin_q, fin_d, vld_q, vld_d, rdy_q, rdy_d;

  // request decode
  logic [2:0]  ctl;
  logic        is_w, is_rem, is_uns, sa, sb, dz, ovf;
  logic [63:0] a_sx, b_sx, a_ext, b_ext, a_mag, b_mag, fast_res;

  always_comb begin
    ctl    = control[3] ? 3'd0 : control[2:0];
    is_w   = ctl[2];
    is_rem = ctl[1];
    is_uns = ctl[0];
    a_sx   = is_w ? {{32{src1[31]}}, src1[31:0]} : src1;
    b_sx   = is_w ? {{32{src2[31]}}, src2[31:0]} : src2;
    a_ext  = (is_w && is_uns) ? {32'd0, src1[31:0]} : a_sx;
    b_ext  = (is_w && is_uns) ? {32'd0, src2[31:0]} : b_sx;
    sa     = !is_uns && a_sx[63];
    sb     = !is_uns && b_sx[63];
    a_mag  = sa ? (~a_ext + 64'd1) : a_ext;
    b_mag  = sb ? (~b_ext + 64'd1) : b_ext;
    dz     = is_w ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
    ovf    = !is_uns && (is_w ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                              : (src1 == 64'h8000_0000_0000_0000 && src2 == '1));
    if (dz) fast_res = is_rem ? a_sx : '1;
    else    fast_res = is_rem ? 64'd0 : a_sx;
  end

  // one restoring step; 66-bit difference keeps the borrow unambiguous for 64-bit divisors
  logic [64:0] shifted;
  logic [65:0] diff;
  logic        qbit;
  logic [63:0] q_raw, q_s, r_s, sel, fin_res;

  always_comb begin
    shifted = {rem_q, quo_q[63]};
    diff    = {1'b0, shifted} + ~{2'b00, dvs_q} + 66'd1;
    qbit    = !diff[65];
    q_raw   = is_w_q ? {32'd0, quo_q[31:0]} : quo_q;
    q_s     = neg_q_q ? (~q_raw + 64'd1) : q_raw;
    r_s     = neg_r_q ? (~rem_q + 64'd1) : rem_q;
    sel     = is_rem_q ? r_s : q_s;
    fin_res = is_w_q ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_w_d   = is_w_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    fin_d    = fin_q;
    res_d    = res_q;
    vld_d    = vld_q;
    case (state_q)
      IDLE: if (in_valid) begin
        is_w_d   = is_w;
        is_rem_d = is_rem;
        neg_q_d  = sa ^ sb;
        neg_r_d  = sa;
        rem_d    = 64'd0;
        quo_d    = is_w ? {a_mag[31:0], 32'd0} : a_mag;
        dvs_d    = b_mag;
        cnt_d    = is_w ? 6'd31 : 6'd63;
        fin_d    = 1'b0;
        if (dz || ovf) begin
          state_d = DONE;
          res_d   = fast_res;
          vld_d   = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (fin_q) begin
          // extra cycle applies signs and W-extension to the finished magnitudes
          state_d = DONE;
          res_d   = fin_res;
          vld_d   = 1'b1;
        end else begin
          rem_d = qbit ? diff[63:0] : shifted[63:0];
          quo_d = {quo_q[62:0], qbit};
          if (cnt_q == 6'd0) fin_d = 1'b1;
          else               cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        res_d   = 64'd0;
        vld_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = 64'd0;
      vld_d   = 1'b0;
      cnt_d   = 6'd0;
      fin_d   = 1'b0;
    end
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 64'd0;
      quo_q    <= 64'd0;
      dvs_q    <= 64'd0;
      is_w_q   <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      fin_q    <= 1'b0;
      res_q    <= 64'd0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_w_q   <= is_w_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      fin_q    <= fin_d;
      res_q    <= res_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = vld_q;
  assign result_out = res_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset; sampled on rising clk only.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-005 SHALL have port: src1  input  64  dividend.
REQ-006 SHALL have port: src2  input  64  divisor.
REQ-007 SHALL have port: control  input  4  op select: 0 DIV, 1 DIVU, 2 REM, 3 REMU, 4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW; 8-15 reserved.
REQ-008 SHALL have port: flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port: out_valid  output  1  result_out valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result_out  output  64  quotient or remainder.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept a request on a clk edge with in_valid & in_ready, latch operands and control, then leave IDLE.
REQ-014 SHALL treat reserved control codes 8-15 as DIV (code 0).
REQ-015 SHALL handle W ops (4-7) as follows: use src[31:0] only, sign- or zero-extend them per op, run 32 iterations, and sign-extend bit 31 of the 32-bit result to 64 bits.
REQ-016 SHALL, for signed ops, divide the operand magnitudes and then fix signs: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
REQ-017 SHALL use radix-2 restoring shift-subtract, one quotient bit per CALC cycle, with the subtract done as a + ~b + 1.
REQ-018 SHALL take, for a normal op, 64 CALC cycles (32 for W ops), then enter DONE; out_valid is high from cycle N+2 after acceptance (N = iteration count).
REQ-019 SHALL, on divide-by-zero (divisor == 0 at the used width), skip CALC and go IDLE -> DONE next edge; the quotient is all ones (W: 0xFFFFFFFF sign-extended), and the remainder equals the dividend (W: sign-extended low word).
REQ-020 SHALL, on signed overflow (most-negative dividend / -1 at the used width), skip CALC; the quotient equals the dividend and the remainder is 0.
REQ-021 SHALL, in DONE, hold out_valid high and result_out stable until out_ready; on the out_valid & out_ready edge it returns to IDLE.
REQ-022 SHALL NOT accept a new request in the same cycle as that result handshake (in_ready=0 in DONE).
REQ-023 SHALL, when flush is high in CALC or DONE, return to IDLE on the next edge, drop the result, and keep out_valid low; flush in IDLE has no effect and does not block acceptance.
REQ-024 SHALL give flush priority over the out_ready handshake in the same cycle, with no result counted as delivered.
REQ-025 SHALL hold the iteration counter in range 0..63 and never wrap into a new iteration after it reaches 0.
REQ-026 SHALL keep result_out at 0 outside DONE.

Reset
REQ-027 SHALL, with rst high at a clk edge, set state=IDLE, out_valid=0, result_out=0, counter=0, and clear the latched operands; in_ready=1 the cycle after.
REQ-028 SHALL give rst priority over flush and all handshakes, including in the middle of CALC, so that no stale result ever appears.

Verification
REQ-029 SHALL pass DIV src1=-20 (0xFFFF_FFFF_FFFF_FFEC), src2=3 -> result_out=0xFFFF_FFFF_FFFF_FFFA (-6) after 66 cycles; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFE (-2).
REQ-030 SHALL pass DIVU src1=100, src2=0 -> DONE one cycle after acceptance with result_out=0xFFFF_FFFF_FFFF_FFFF; REMU on the same operands -> 100.
REQ-031 SHALL pass DIV src1=0x8000_0000_0000_0000, src2=-1 -> result_out=0x8000_0000_0000_0000 with the fast path; REM on the same operands -> 0.
REQ-032 SHALL pass DIVW src1=0x0000_0001_8000_0000, src2=0xFFFF_FFFF -> result_out=0xFFFF_FFFF_8000_0000; REMUW src1=7, src2=2 -> 1 after 34 cycles.
REQ-033 SHALL pass: out_ready held low 10 cycles in DONE -> out_valid and result_out stable throughout, in_ready=0, then IDLE one edge after out_ready=1.
REQ-034 SHALL pass: flush asserted at CALC iteration 20, or rst asserted at iteration 40 -> IDLE next edge, out_valid never asserted, and a following DIVU 9/4 returns 2.
